// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// DM has fixed priority. The granted request is held on the memory side until completion or watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_ren,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic                dm_ren,
  input  logic                dm_wen,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_stall,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  input  logic                mem_wvalid,
  output logic                err_timeout
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic              WD_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               ren_nxt, wen_nxt, err_nxt;
  logic [DATA_W-1:0]  wdata_nxt;
  logic [MASK_W-1:0]  wmask_nxt;
  logic               dm_req, busy, done, abort, release_now;

  // Completion only counts the owner's own response type; the other valid is ignored.
  always_comb begin
    dm_req      = dm_ren | dm_wen;
    busy        = (state != IDLE);
    done        = ((state == BUSY_IF) && mem_rvalid) ||
                  ((state == BUSY_DM) && (mem_wen ? mem_wvalid : mem_rvalid));
    abort       = WD_EN && busy && !done && (wd_cnt == WD_LAST);
    release_now = done | abort;
  end

  assign if_stall = if_ren && !((state == BUSY_IF) && release_now);
  assign dm_stall = dm_req && !((state == BUSY_DM) && release_now);
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

  always_comb begin
    state_nxt  = state;
    wd_cnt_nxt = wd_cnt;
    addr_nxt   = mem_addr;
    ren_nxt    = mem_ren;
    wen_nxt    = mem_wen;
    wdata_nxt  = mem_wdata;
    wmask_nxt  = mem_wmask;
    err_nxt    = err_timeout | abort;
    case (state)
      IDLE: begin
        ren_nxt    = 1'b0;
        wen_nxt    = 1'b0;
        wd_cnt_nxt = '0;
        if (dm_req) begin
          state_nxt = BUSY_DM;
          addr_nxt  = dm_addr;
          wdata_nxt = dm_wdata;
          wmask_nxt = dm_wmask;
          wen_nxt   = dm_wen;
          ren_nxt   = !dm_wen;
        end else if (if_ren) begin
          state_nxt = BUSY_IF;
          addr_nxt  = if_addr;
          ren_nxt   = 1'b1;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (release_now) begin
          state_nxt  = IDLE;
          ren_nxt    = 1'b0;
          wen_nxt    = 1'b0;
          wd_cnt_nxt = '0;
        end else if (WD_EN) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ren_nxt   = 1'b0;
        wen_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      mem_addr    <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wd_cnt      <= wd_cnt_nxt;
      mem_addr    <= addr_nxt;
      mem_ren     <= ren_nxt;
      mem_wen     <= wen_nxt;
      mem_wdata   <= wdata_nxt;
      mem_wmask   <= wmask_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule
